xgmii_decoder: RTL and testbench

- Receive-side 64b/66b decoder for the 10GBASE-R PCS. Sits between the descrambler and the MAC's XGMII receive interface.
- Accepts each 66-bit block as a 2-bit sync header plus two 32-bit halves. Emits two 32-bit XGMII lane words (rxd/rxc) per block.
- Enforces the receive frame sequence (Start/Data/Terminate/Control) and replaces malformed blocks with XGMII error words.

---
 rtl/xgmii_decoder.sv | 128 ++++++++++++
 tb/tb_xgmii_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xgmii_decoder.sv
// xgmii_decoder: 10GBASE-R receive 64b/66b block decoder producing two XGMII words per block
module xgmii_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_encoded_data,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  input  logic                  i_hdr_valid,
  input  logic                  i_data_valid,
  output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
  output logic                  o_xgmii_valid,
  output logic                  o_decoding_err
);
  typedef enum logic {WAIT_LO, WAIT_HI} coll_t;
  typedef enum logic {IDLE, FRAME} frame_t;
  typedef enum logic [2:0] {K_C, K_S, K_D, K_T, K_E} kind_t;
  // Terminate block type for T_k sits in byte k
  localparam logic [63:0] T_TYPES = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};

  function automatic logic [8:0] map_code(input logic [6:0] c);
    return c == 7'h00 ? 9'h007 : c == 7'h06 ? 9'h006 : c == 7'h1E ? 9'h0FE :
           c == 7'h2D ? 9'h01C : c == 7'h33 ? 9'h03C : c == 7'h4B ? 9'h07C :
           c == 7'h55 ? 9'h0BC : c == 7'h66 ? 9'h0DC : c == 7'h78 ? 9'h0F7 : 9'h1FE;
  endfunction

  coll_t        st;
  frame_t       fs;
  logic [1:0]   hdr_q, blk_hdr;
  logic [31:0]  lo_q, hi_d;
  logic [3:0]   hi_c;
  logic [63:0]  blk, d, pd;
  logic [7:0]   c;
  logic         pend, hi_pend, code_err, bad, coll_err;
  kind_t        kind;
  logic [8:0]   mc [8];

  always_comb begin
    pd = {8'h00, blk[63:8]};
    for (int i = 0; i < 8; i++) mc[i] = map_code(blk[8+7*i +: 7]);
    d = {8{8'hFE}};
    c = 8'hFF;
    kind = K_E;
    code_err = 1'b0;
    if (blk_hdr == 2'b01) begin
      d = blk;
      c = 8'h00;
      kind = K_D;
    end else if (blk_hdr == 2'b10) begin
      if (blk[7:0] == 8'h1E) begin
        kind = K_C;
        for (int i = 0; i < 8; i++) begin
          d[8*i +: 8] = mc[i][7:0];
          code_err = code_err | mc[i][8];
        end
      end else if (blk[7:0] == 8'h78) begin
        d = {blk[63:8], 8'hFB};
        c = 8'h01;
        kind = K_S;
      end else if (blk[7:0] == 8'h33) begin
        d = {blk[63:40], 8'hFB, mc[3][7:0], mc[2][7:0], mc[1][7:0], mc[0][7:0]};
        c = 8'h1F;
        kind = K_S;
        code_err = mc[0][8] | mc[1][8] | mc[2][8] | mc[3][8];
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (blk[7:0] == T_TYPES[8*k +: 8]) begin
            kind = K_T;
            for (int j = 0; j < 8; j++) begin
              d[8*j +: 8] = j < k ? pd[8*j +: 8] : j == k ? 8'hFD : 8'h07;
              c[j] = j >= k;
            end
          end
        end
      end
    end
    bad = kind == K_E || (fs == FRAME ? (kind == K_S || kind == K_C) : (kind == K_D || kind == K_T));
    coll_err = i_data_valid && (st == WAIT_LO ? !i_hdr_valid : i_hdr_valid);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st <= WAIT_LO;
      fs <= IDLE;
      pend <= 1'b0;
      hi_pend <= 1'b0;
      o_xgmii_rxd <= 32'h07070707;
      o_xgmii_rxc <= 4'hF;
      o_xgmii_valid <= 1'b0;
      o_decoding_err <= 1'b0;
    end else begin
      o_decoding_err <= coll_err || (pend && (bad || code_err));
      pend <= 1'b0;
      // a header beat always starts a fresh block, abandoning any partial one
      if (i_data_valid) begin
        if (i_hdr_valid) begin
          hdr_q <= i_sync_hdr;
          lo_q <= i_encoded_data;
          st <= WAIT_HI;
        end else if (st == WAIT_HI) begin
          blk_hdr <= hdr_q;
          blk <= {i_encoded_data, lo_q};
          pend <= 1'b1;
          st <= WAIT_LO;
        end
      end
      if (pend) begin
        o_xgmii_rxd <= bad ? 32'hFEFEFEFE : d[31:0];
        o_xgmii_rxc <= bad ? 4'hF : c[3:0];
        hi_d <= bad ? 32'hFEFEFEFE : d[63:32];
        hi_c <= bad ? 4'hF : c[7:4];
        hi_pend <= 1'b1;
        o_xgmii_valid <= 1'b1;
        fs <= (kind == K_S || (fs == FRAME && kind == K_D)) ? FRAME : IDLE;
      end else begin
        hi_pend <= 1'b0;
        o_xgmii_valid <= hi_pend;
        if (hi_pend) begin
          o_xgmii_rxd <= hi_d;
          o_xgmii_rxc <= hi_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_xgmii_decoder.sv
// tb_xgmii_decoder: directed table-driven check of the XGMII receive decoder
module tb_xgmii_decoder;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_encoded_data = '0;
  logic [1:0]  i_sync_hdr = '0;
  logic        i_hdr_valid = 1'b0;
  logic        i_data_valid = 1'b0;
  logic [31:0] o_xgmii_rxd;
  logic [3:0]  o_xgmii_rxc;
  logic        o_xgmii_valid;
  logic        o_decoding_err;
  int          errors = 0;
  int          checks = 0;

  xgmii_decoder dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_encoded_data(i_encoded_data), .i_sync_hdr(i_sync_hdr),
    .i_hdr_valid(i_hdr_valid), .i_data_valid(i_data_valid), .o_xgmii_rxd(o_xgmii_rxd),
    .o_xgmii_rxc(o_xgmii_rxc), .o_xgmii_valid(o_xgmii_valid), .o_decoding_err(o_decoding_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  hdr;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] lo_d;
    logic [3:0]  lo_c;
    logic [31:0] hi_d;
    logic [3:0]  hi_c;
    logic        err;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic beat(input logic hv, input logic [1:0] h, input logic [31:0] w);
    i_data_valid = 1'b1;
    i_hdr_valid = hv;
    i_sync_hdr = h;
    i_encoded_data = w;
    @(posedge i_clk);
    @(negedge i_clk);
    i_data_valid = 1'b0;
    i_hdr_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic expect_blk(input string nm, input logic [31:0] lo_d, input logic [3:0] lo_c,
                            input logic [31:0] hi_d, input logic [3:0] hi_c, input logic e);
    tick();
    chk({nm, "_lo_valid"}, o_xgmii_valid, 1);
    chk({nm, "_lo_rxd"}, o_xgmii_rxd, lo_d);
    chk({nm, "_lo_rxc"}, o_xgmii_rxc, lo_c);
    chk({nm, "_lo_err"}, o_decoding_err, e);
    tick();
    chk({nm, "_hi_valid"}, o_xgmii_valid, 1);
    chk({nm, "_hi_rxd"}, o_xgmii_rxd, hi_d);
    chk({nm, "_hi_rxc"}, o_xgmii_rxc, hi_c);
    chk({nm, "_hi_err"}, o_decoding_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{2'b10, 32'h0000001E, 32'h00000000, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0};
    v[1]  = '{2'b10, 32'hAABBCC78, 32'h11223344, 32'hAABBCCFB, 4'h1, 32'h11223344, 4'h0, 1'b0};
    v[2]  = '{2'b01, 32'hDEADBEEF, 32'h01020304, 32'hDEADBEEF, 4'h0, 32'h01020304, 4'h0, 1'b0};
    v[3]  = '{2'b10, 32'h332211B4, 32'h00000000, 32'hFD332211, 4'h8, 32'h07070707, 4'hF, 1'b0};
    v[4]  = '{2'b11, 32'h0000001E, 32'h00000000, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
    v[5]  = '{2'b10, 32'h0000002D, 32'h00000000, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
    v[6]  = '{2'b01, 32'h12345678, 32'h9ABCDEF0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
    v[7]  = '{2'b10, 32'h00000087, 32'h00000000, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
    v[8]  = '{2'b10, 32'hAABBCC78, 32'h11223344, 32'hAABBCCFB, 4'h1, 32'h11223344, 4'h0, 1'b0};
    v[9]  = '{2'b10, 32'hAABBCC78, 32'h11223344, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
    v[10] = '{2'b01, 32'hDEADBEEF, 32'h01020304, 32'hDEADBEEF, 4'h0, 32'h01020304, 4'h0, 1'b0};
    v[11] = '{2'b10, 32'h0000001E, 32'h00000000, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
    v[12] = '{2'b10, 32'h00007F1E, 32'h00000000, 32'h070707FE, 4'hF, 32'h07070707, 4'hF, 1'b1};
    v[13] = '{2'b10, 32'h00000033, 32'hA1B2C350, 32'h07070707, 4'hF, 32'hA1B2C3FB, 4'h1, 1'b0};
    v[14] = '{2'b10, 32'hCCBBAAFF, 32'h44332211, 32'h11CCBBAA, 4'h0, 32'hFD443322, 4'h8, 1'b0};

    repeat (3) tick();
    chk("rst_rxd", o_xgmii_rxd, 32'h07070707);
    chk("rst_rxc", o_xgmii_rxc, 4'hF);
    chk("rst_valid", o_xgmii_valid, 0);
    chk("rst_err", o_decoding_err, 0);
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      beat(1'b1, v[i].hdr, v[i].lo);
      beat(1'b0, 2'b00, v[i].hi);
      chk($sformatf("v%0d_pre_valid", i), o_xgmii_valid, 0);
      expect_blk($sformatf("v%0d", i), v[i].lo_d, v[i].lo_c, v[i].hi_d, v[i].hi_c, v[i].err);
      tick();
      chk($sformatf("v%0d_idle_valid", i), o_xgmii_valid, 0);
    end

    // two header beats in a row: first is abandoned, second pairs with next beat
    beat(1'b1, 2'b10, 32'hDEADBE78);
    beat(1'b1, 2'b10, 32'h0000001E);
    chk("realign_err", o_decoding_err, 1);
    beat(1'b0, 2'b00, 32'h00000000);
    chk("realign_err_clear", o_decoding_err, 0);
    expect_blk("realign", 32'h07070707, 4'hF, 32'h07070707, 4'hF, 0);
    tick();

    // high-half beat with no pending low half is dropped
    beat(1'b0, 2'b00, 32'h12345678);
    chk("drop_err", o_decoding_err, 1);
    chk("drop_valid", o_xgmii_valid, 0);
    tick();
    chk("drop_err_clear", o_decoding_err, 0);
    chk("drop_no_out", o_xgmii_valid, 0);

    // gap of three idle cycles between halves
    beat(1'b1, 2'b10, 32'hAABBCC78);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gap%0d_valid", i), o_xgmii_valid, 0);
    end
    beat(1'b0, 2'b00, 32'h11223344);
    expect_blk("gap", 32'hAABBCCFB, 4'h1, 32'h11223344, 4'h0, 0);

    // back-to-back D then T3 while in a frame: continuous output
    beat(1'b1, 2'b01, 32'hDEADBEEF);
    beat(1'b0, 2'b00, 32'h01020304);
    beat(1'b1, 2'b10, 32'h332211B4);
    chk("b2b_w0_rxd", o_xgmii_rxd, 32'hDEADBEEF);
    chk("b2b_w0_valid", o_xgmii_valid, 1);
    beat(1'b0, 2'b00, 32'h00000000);
    chk("b2b_w1_rxd", o_xgmii_rxd, 32'h01020304);
    chk("b2b_w1_valid", o_xgmii_valid, 1);
    expect_blk("b2b_t3", 32'hFD332211, 4'h8, 32'h07070707, 4'hF, 0);
    tick();

    // reset between halves discards the partial block
    beat(1'b1, 2'b00, 32'h0000001E);
    beat(1'b0, 2'b00, 32'h00000000);
    expect_blk("pre_rst", 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1);
    beat(1'b1, 2'b01, 32'hCAFEF00D);
    i_reset = 1'b1;
    tick();
    chk("mid_rst_rxd", o_xgmii_rxd, 32'h07070707);
    chk("mid_rst_rxc", o_xgmii_rxc, 4'hF);
    chk("mid_rst_valid", o_xgmii_valid, 0);
    chk("mid_rst_err", o_decoding_err, 0);
    i_reset = 1'b0;
    beat(1'b0, 2'b00, 32'h55555555);
    chk("post_rst_drop_err", o_decoding_err, 1);
    chk("post_rst_valid", o_xgmii_valid, 0);
    tick();
    chk("post_rst_no_out", o_xgmii_valid, 0);
    tick();
    chk("post_rst_no_out2", o_xgmii_valid, 0);
    beat(1'b1, 2'b10, 32'h0000001E);
    beat(1'b0, 2'b00, 32'h00000000);
    expect_blk("post_rst", 32'h07070707, 4'hF, 32'h07070707, 4'hF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
